// File: rtl/counter_seq_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the counter command sequencer.
`default_nettype none

package counter_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  localparam int WIDTH_DEF = 4;
  localparam int DUR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_duration_timer.sv
// Duration down-counter: loaded with N on command accept, decremented once per active cycle.
`default_nettype none

module seq_duration_timer
  import counter_seq_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             dec,
  output logic             last,
  output logic             zero
);

  logic [DUR_W-1:0] remaining;

  // Saturates at zero so a stray decrement can never wrap to a huge duration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (dec && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == DUR_W'(1));
  assign zero = (remaining == '0);

endmodule

`default_nettype wire

// File: rtl/counter_cmd_sequencer.sv
// Command-driven controller for up_down_counter (LOAD / UP N / DOWN N / HOLD N, done pulse).
// Optional SEQ_ABORT_EN adds an abort input and a one-cycle aborted pulse.
`default_nettype none

module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_arg,
`ifdef SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             enable,
  output logic             up_down,
  output logic             load,
  output logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             done
);

  state_t state;
  logic   accept;
  logic   timer_dec;
  logic   timer_last;
  logic   timer_zero;
  logic   finish;
  logic   abort_req;

  assign accept    = cmd_valid && cmd_ready;
  assign timer_dec = (state == ST_RUN) || (state == ST_HOLD);
  assign finish    = timer_last || timer_zero;

`ifdef SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  seq_duration_timer #(
    .DUR_W(DUR_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(cmd_arg),
    .dec     (timer_dec),
    .last    (timer_last),
    .zero    (timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      enable    <= 1'b0;
      up_down   <= 1'b0;
      load      <= 1'b0;
      load_val  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept) begin
            case (cmd_op)
              OP_LOAD: begin
                state     <= ST_LOAD;
                load      <= 1'b1;
                load_val  <= cmd_arg[WIDTH-1:0];
                cmd_ready <= 1'b0;
                busy      <= 1'b1;
              end
              OP_UP, OP_DOWN: begin
                // A zero-length count completes at once and leaves up_down untouched.
                if (cmd_arg == '0) begin
                  done <= 1'b1;
                end else begin
                  state     <= ST_RUN;
                  enable    <= 1'b1;
                  up_down   <= (cmd_op == OP_UP);
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                end
              end
              default: begin
                if (cmd_arg == '0) begin
                  done <= 1'b1;
                end else begin
                  state     <= ST_HOLD;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                end
              end
            endcase
          end
        end
        ST_LOAD: begin
          state     <= ST_IDLE;
          load      <= 1'b0;
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          if (abort_req) begin
            state     <= ST_IDLE;
            enable    <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
`ifdef SEQ_ABORT_EN
            aborted   <= 1'b1;
`endif
          end else if (finish) begin
            state     <= ST_IDLE;
            enable    <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
- Command-driven control stage that sits directly upstream of up_down_counter and drives its enable, up_down, load and load_val inputs.
- Accepts timed commands over a valid/ready handshake: LOAD a value, count UP for N cycles, count DOWN for N cycles, or HOLD for N cycles.
- Signals completion of each command with a one-cycle done pulse.
- Replaces hand-written stimulus sequences with a hardware-sequenced control path.

Parameters:
- WIDTH, 4, width of load_val; must match the downstream counter width.
- DUR_W, 8, width of cmd_arg and of the internal duration counter; must be >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  opcode: 00 HOLD, 01 LOAD, 10 UP, 11 DOWN.
- cmd_arg  input  DUR_W  cycle count N for HOLD/UP/DOWN; for LOAD, bits [WIDTH-1:0] are the load value and upper bits are ignored.
- enable  output  1  to counter enable.
- up_down  output  1  to counter up_down (1 = up).
- load  output  1  to counter load.
- load_val  output  WIDTH  to counter load_val.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse on command completion.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All outputs are registered.
- Reset values: cmd_ready=0, enable=0, up_down=0, load=0, load_val=0, busy=0, done=0; state=IDLE; duration counter=0.
- First clk edge after reset deasserts sets cmd_ready=1.
- States: IDLE, LOAD, RUN, HOLD.
- IDLE: cmd_ready=1, busy=0. A command is accepted on a rising edge where cmd_valid && cmd_ready; cmd_op and cmd_arg are sampled only at that edge. cmd_valid while cmd_ready=0 is ignored (no queuing).
- Timing, with the accept edge ending cycle k:
  - LOAD: cycle k+1 has load=1, load_val=cmd_arg[WIDTH-1:0], enable=0. Cycle k+2: back in IDLE with done=1.
  - UP/DOWN, N>=1: cycles k+1..k+N have enable=1 and up_down=1 (UP) or 0 (DOWN). Cycle k+N+1: enable=0, IDLE, done=1.
  - HOLD, N>=1: cycles k+1..k+N have enable=0 and busy=1. Cycle k+N+1: IDLE, done=1.
  - N=0 for UP/DOWN/HOLD: no active cycles; cycle k+1 is IDLE with done=1, so 0 counter steps.
- In every non-IDLE state, cmd_ready=0 and busy=1.
- done and cmd_ready=1 coincide, so a back-to-back command can be accepted at the edge ending the done cycle. Throughput is N+1 cycles per timed command and 2 cycles per LOAD.
- up_down holds its last driven value in IDLE, HOLD and LOAD. load_val holds the last loaded value. load is high only in the LOAD state.
- Duration counter: loaded with N at accept, decremented each RUN/HOLD cycle, exit when it reaches 1→0 transition. No wrap: max N = 2^DUR_W−1.
- Reset mid-command: all outputs go to reset values immediately, the in-flight command is discarded, and no done is pulsed.

Optional Feature:
- Macro SEQ_ABORT_EN.
- When defined, adds input abort (1) and output aborted (1).
  - abort sampled high in RUN or HOLD: next cycle has enable=0, state=IDLE, cmd_ready=1, aborted=1 for one cycle, and done=0.
  - abort in IDLE or LOAD has no effect; LOAD always completes.
- When undefined, neither port exists and behaviour is as above.

Decomposition:
- Shared package counter_seq_pkg holds:
  - opcode localparams OP_HOLD=2'b00, OP_LOAD=2'b01, OP_UP=2'b10, OP_DOWN=2'b11;
  - state encoding IDLE/LOAD/RUN/HOLD;
  - default WIDTH/DUR_W.
- One natural sub-module, seq_duration_timer: load N, decrement on enable, zero flag. The FSM and output registers stay in the top module.

Test Plan:
- Reset release → cmd_ready 0 during reset, 1 after the first edge; all other outputs 0.
- LOAD arg=5 → load=1 for exactly 1 cycle with load_val=5, then done=1 in the next cycle. With up_down_counter attached, count=5.
- LOAD 5, then UP N=5 issued back-to-back on the done cycle → enable=1, up_down=1 for exactly 5 cycles; count=10; done after the 5th cycle.
- DOWN N=12 from count=10 → 12 enable cycles, up_down=0; counter wraps to 14 (4-bit); up_down stays 0 afterwards.
- UP N=0 and HOLD N=3 → UP: done the next cycle with no enable. HOLD: busy for 3 cycles, enable=0, count unchanged.
- Reset asserted in cycle 3 of UP N=8 → enable drops immediately, no done, cmd_ready returns after reset. With SEQ_ABORT_EN: abort in cycle 3 → aborted=1, done=0, exactly 3 count steps.
